// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction fetcher: redirects the PC from the execute-stage
// branch select and runs a req/ack fetch handshake. Optional perf counters: define PERF_CNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          FAULT_ON_MISALIGN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  branch,
  input  logic        branch_valid,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fault
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_taken
`endif
);

  // state    | meaning
  // ST_FETCH | request outstanding at pc_q, waiting for imem_ack
  // ST_EXEC  | instruction handed to decode, waiting for branch_valid
  // ST_FAULT | misaligned redirect trapped; only rst leaves
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam bit FAULT_EN = (FAULT_ON_MISALIGN != 0);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        misaligned;
  logic        ack_accept;
  logic        redirect;
  logic        do_fault;

`ifdef PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] taken_q, taken_d;
`endif

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    target = pc_inc;
    unique case (branch)
      2'b01:   target = pc_q + imm;
      2'b10:   target = alu_out & ~32'h1;
      default: target = pc_inc;
    endcase
  end

  assign misaligned = |target[1:0];
  // An ack only counts while a request is actually on the bus.
  assign ack_accept = (state_q == ST_FETCH) && req_q && imem_ack;
  assign redirect   = (state_q == ST_EXEC) && branch_valid;
  assign do_fault   = redirect && misaligned && FAULT_EN;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: if (ack_accept) state_d = ST_EXEC;
      ST_EXEC:  if (redirect)   state_d = do_fault ? ST_FAULT : ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // output / datapath next values
  always_comb begin
    pc_d    = pc_q;
    req_d   = (state_d == ST_FETCH);
    instr_d = instr_q;
    valid_d = ack_accept;
    fault_d = fault_q | do_fault;
    if (ack_accept) begin
      instr_d = imem_rdata;
    end
    // Non-faulting redirects always land word-aligned; low bits are dropped when not trapping.
    if (redirect && !do_fault) begin
      pc_d = {target[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

`ifdef PERF_CNT_EN
  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (redirect && !do_fault) begin
      retired_d = retired_q + 32'd1;
      if ((branch == 2'b01) || (branch == 2'b10)) begin
        taken_d = taken_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'h0;
      taken_q   <= 32'h0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_taken   = taken_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_inc;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

endmodule
